// File: rtl/instruction_encoder_pkg.sv
// Shared definitions for the RV64 load/store/branch instruction encoder:
// opcode constants, format encoding, pipeline payload types and field helpers.
package instruction_encoder_pkg;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;

  typedef enum logic [1:0] {
    FmtNone = 2'd0,
    FmtI    = 2'd1,
    FmtS    = 2'd2,
    FmtB    = 2'd3
  } fmt_e;

  // Only imm[12:0] is ever placed in a word, so S1 keeps just those bits.
  typedef struct packed {
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [12:0] imm;
    fmt_e        fmt;
    logic        err;
  } s1_t;

  typedef struct packed {
    logic        err;
    logic [31:0] instr;
  } s2_t;

  function automatic fmt_e decode_fmt(logic [6:0] opcode);
    fmt_e fmt;
    fmt = FmtNone;
    case (opcode)
      OpLoad, OpImm, OpJalr: fmt = FmtI;
      OpStore:               fmt = FmtS;
      OpBranch:              fmt = FmtB;
      default:               fmt = FmtNone;
    endcase
    return fmt;
  endfunction

  function automatic logic imm_fits(fmt_e fmt, logic [63:0] imm);
    logic ok;
    ok = 1'b0;
    case (fmt)
      FmtI, FmtS: ok = (&imm[63:11]) || !(|imm[63:11]);
      // Branch offsets are halfword aligned; bit 0 is not encoded.
      FmtB:       ok = ((&imm[63:12]) || !(|imm[63:12])) && !imm[0];
      default:    ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic s2_t encode_word(s1_t s);
    s2_t w;
    w.err   = s.err;
    w.instr = 32'h0;
    if (!s.err) begin
      case (s.fmt)
        FmtI: w.instr = {s.imm[11:0], s.rs1, s.funct3, s.rd, s.opcode};
        FmtS: w.instr = {s.imm[11:5], s.rs2, s.rs1, s.funct3, s.imm[4:0], s.opcode};
        FmtB: w.instr = {s.imm[12], s.imm[10:5], s.rs2, s.rs1, s.funct3,
                         s.imm[4:1], s.imm[11], s.opcode};
        default: w.instr = 32'h0;
      endcase
    end
    return w;
  endfunction

endpackage

// File: rtl/instruction_encoder_if.sv
// Request/response bus of the instruction encoder; master drives requests,
// slave is the encoder.
interface instruction_encoder_if #(
  parameter int unsigned ERR_CNT_W = 16
) ();

  logic                 in_valid;
  logic                 in_ready;
  logic [6:0]           in_opcode;
  logic [4:0]           in_rd;
  logic [4:0]           in_rs1;
  logic [4:0]           in_rs2;
  logic [2:0]           in_funct3;
  logic [63:0]          in_imm;
  logic                 out_valid;
  logic                 out_ready;
  logic [31:0]          out_instr;
  logic                 out_err;
  logic [ERR_CNT_W-1:0] err_count;

  modport master (
    output in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_imm, out_ready,
    input  in_ready, out_valid, out_instr, out_err, err_count
  );

  modport slave (
    input  in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_imm, out_ready,
    output in_ready, out_valid, out_instr, out_err, err_count
  );

endinterface

// File: rtl/encoder_pipe_stage.sv
// Generic valid/ready register slice; accepts whenever empty or draining.
module encoder_pipe_stage #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [Width-1:0] i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [Width-1:0] o_data
);

  logic             r_valid;
  logic [Width-1:0] r_data;

  assign o_ready = !r_valid || i_ready;
  assign o_valid = r_valid;
  assign o_data  = r_data;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (o_ready) begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_data <= i_data;
      end
    end
  end

endmodule

// File: rtl/instruction_encoder.sv
// RV64 I/S/B instruction encoder: S1 registers fields, format and range error,
// S2 registers the final word; saturating count of delivered error words.
module instruction_encoder
  import instruction_encoder_pkg::*;
#(
  parameter int unsigned ERR_CNT_W = 16
) (
  input logic                 clk,
  input logic                 rst_n,
  instruction_encoder_if.slave bus
);

  logic                 r_active;
  logic [ERR_CNT_W-1:0] r_err_count;

  fmt_e w_fmt;
  s1_t  w_s1_d;
  s1_t  w_s1_q;
  s2_t  w_s2_d;
  s2_t  w_s2_q;
  logic w_s1_in_valid;
  logic w_s1_ready;
  logic w_s1_valid;
  logic w_s2_ready;
  logic w_s2_valid;
  logic w_out_xfer;

  // Holds in_ready low until the first edge with rst_n high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_active <= 1'b0;
    end else begin
      r_active <= 1'b1;
    end
  end

  always_comb begin
    w_fmt         = decode_fmt(bus.in_opcode);
    w_s1_d.opcode = bus.in_opcode;
    w_s1_d.rd     = bus.in_rd;
    w_s1_d.rs1    = bus.in_rs1;
    w_s1_d.rs2    = bus.in_rs2;
    w_s1_d.funct3 = bus.in_funct3;
    w_s1_d.imm    = bus.in_imm[12:0];
    w_s1_d.fmt    = w_fmt;
    w_s1_d.err    = (w_fmt == FmtNone) || !imm_fits(w_fmt, bus.in_imm);
  end

  assign w_s1_in_valid = bus.in_valid && r_active;
  assign bus.in_ready  = w_s1_ready && r_active;

  encoder_pipe_stage #(
    .Width ($bits(s1_t))
  ) u_s1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (w_s1_in_valid),
    .o_ready (w_s1_ready),
    .i_data  (w_s1_d),
    .o_valid (w_s1_valid),
    .i_ready (w_s2_ready),
    .o_data  (w_s1_q)
  );

  assign w_s2_d = encode_word(w_s1_q);

  encoder_pipe_stage #(
    .Width ($bits(s2_t))
  ) u_s2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (w_s1_valid),
    .o_ready (w_s2_ready),
    .i_data  (w_s2_d),
    .o_valid (w_s2_valid),
    .i_ready (bus.out_ready),
    .o_data  (w_s2_q)
  );

  assign bus.out_valid = w_s2_valid;
  assign bus.out_instr = w_s2_q.instr;
  assign bus.out_err   = w_s2_q.err;
  assign w_out_xfer    = w_s2_valid && bus.out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_err_count <= '0;
    end else if (w_out_xfer && w_s2_q.err && (r_err_count != '1)) begin
      r_err_count <= r_err_count + 1'b1;
    end
  end

  assign bus.err_count = r_err_count;

endmodule

// File: doc/instruction_encoder.md
INSTRUCTION_ENCODER -- requirements
Module: instruction_encoder

Interface
REQ-001 Parameter: ERR_CNT_W, default 16, width of the saturating error counter.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  1  request carries a field set to encode.
REQ-005 in_ready  output  1  encoder accepts the request this cycle.
REQ-006 in_opcode  input  7  RV64 major opcode.
REQ-007 in_rd, in_rs1, in_rs2  input  5 each  register indices.
REQ-008 in_funct3  input  3  funct3 field.
REQ-009 in_imm  input  64  sign-extended immediate, byte offset for branches.
REQ-010 out_valid  output  1  encoded word available.
REQ-011 out_ready  input  1  consumer accepts the word this cycle.
REQ-012 out_instr  output  32  encoded instruction word.
REQ-013 out_err  output  1  request was unencodable; out_instr is 32'h0.
REQ-014 err_count  output  ERR_CNT_W  number of out_err words delivered, saturating.

Function
REQ-015 Format from opcode: 0000011, 0010011, 1100111 are I; 0100011 is S; 1100011 is B; any other opcode is an error.
REQ-016 I encoding: {imm[11:0], rs1, funct3, rd, opcode}.
REQ-017 S encoding: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
REQ-018 B encoding: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
REQ-019 I/S range check: in_imm[63:11] all equal, otherwise error.
REQ-020 B range check: in_imm[63:12] all equal and in_imm[0]==0, otherwise error.
REQ-021 On any error: out_instr=32'h0, out_err=1.
REQ-022 Pipeline has two register stages: S1 captures fields, format and error flag; S2 holds the final word.
REQ-023 Latency: a request accepted in cycle N appears on out_valid in cycle N+2 when there is no backpressure.
REQ-024 Throughput: one request per cycle while out_ready=1.
REQ-025 Handshake: a transfer occurs when valid&&ready on the same edge; out_instr and out_err stay stable while out_valid=1 and out_ready=0.
REQ-026 Ready chaining: s2_ready = !s2_valid || out_ready; s1_ready = !s1_valid || s2_ready; in_ready = s1_ready.
REQ-027 A full pipeline under backpressure holds exactly 2 requests; none are dropped, duplicated or reordered.
REQ-028 err_count increments by 1 on each out transfer with out_err=1 and holds at all-ones.
REQ-029 in_ready may depend combinationally on out_ready; no other input-to-output combinational path is permitted.

Reset
REQ-030 While rst_n=0 at a clock edge: S1/S2 valid flags clear, out_valid=0, out_err=0, out_instr=32'h0, err_count=0.
REQ-031 in_ready=0 during reset and 1 in the first cycle after rst_n returns high.
REQ-032 Reset asserted mid-operation discards in-flight requests; none are emitted after reset.

Structure
REQ-033 Opcode constants and the format encoding (I, S, B, NONE; 2 bits) SHALL reside in a shared package, also used by the immediate decoder.
REQ-034 One sub-module, encoder_pipe_stage (a generic valid/ready register slice), SHALL be instantiated for S1 and S2.

Verification
REQ-035 addi: opcode 0010011, rd=1, rs1=2, funct3=0, imm=-1 -> out_instr=32'hFFF10093, out_err=0, two cycles after acceptance.
REQ-036 sd: opcode 0100011, rs1=2, rs2=5, funct3=3, imm=8 -> out_instr=32'h00513423.
REQ-037 beq: opcode 1100011, rs1=1, rs2=2, funct3=0, imm=-4 -> 32'hFE208EE3. Second request with imm=3 -> out_err=1, out_instr=0, err_count=1.
REQ-038 I-type imm=2048, then opcode 0110111 -> both produce out_err=1 and err_count=2. Hold out_ready=1 and issue 2^ERR_CNT_W+1 errors -> err_count saturates.
REQ-039 Backpressure: out_ready=0 for 4 cycles while 3 requests are offered -> 2 accepted, in_ready=0 after that, and all 3 are delivered in order once out_ready=1.
REQ-040 Reset with both stages full -> the next cycle shows out_valid=0 and err_count=0, and no stale word appears afterwards.
